// File: rtl/dcache_inval_sequencer_pkg.sv
// Shared constants and types for the dcache full-invalidate sequencer.
package dcache_inval_sequencer_pkg;

  // Cache geometry defaults, matching the dcache arrays.
  localparam int unsigned DCACHE_SET_ASSOC   = 8;
  localparam int unsigned DCACHE_NUM_WORDS   = 256;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_BYTE_OFFSET = 4;

  // Widest way count the lane-mask helper supports.
  localparam int unsigned VLDRTY_MAX_WAYS = 32;

  // Sequencer states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2,
    ACK   = 2'd3
  } inval_state_e;

  // Byte-enable mask selecting the dirty (lane 0) and valid (lane 1) bytes of every way.
  function automatic logic [8*VLDRTY_MAX_WAYS-1:0] vldrty_be_all(input int unsigned num_ways);
    logic [8*VLDRTY_MAX_WAYS-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < VLDRTY_MAX_WAYS; i++) begin
      if (i < num_ways) begin
        mask[8*i +: 2] = 2'b11;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/dcache_inval_sequencer.sv
// Sweeps every dcache set through one SRAM arbiter port, clearing valid/dirty of all ways.
// Runs once after reset when init_ni is low, and again on each software invalidate request.
module dcache_inval_sequencer
  import dcache_inval_sequencer_pkg::*;
#(
  parameter int unsigned NumWays    = DCACHE_SET_ASSOC,
  parameter int unsigned NumSets    = DCACHE_NUM_WORDS,
  parameter int unsigned IndexWidth = DCACHE_INDEX_WIDTH,
  parameter int unsigned ByteOffset = DCACHE_BYTE_OFFSET
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    init_ni,
  input  logic                    inval_req_i,
  output logic                    inval_ack_o,
  output logic                    busy_o,
  output logic [NumWays-1:0]      req_o,
  output logic [IndexWidth-1:0]   addr_o,
  output logic                    we_o,
  output logic [8*NumWays-1:0]    be_vldrty_o,
  output logic [8*NumWays-1:0]    wdata_vldrty_o,
  input  logic                    gnt_i
);

  localparam int unsigned CntWidth = $clog2(NumSets);
  localparam int unsigned BeWidth  = 8 * NumWays;
  localparam logic [CntWidth-1:0] LastSet = CntWidth'(NumSets - 1);
  localparam logic [BeWidth-1:0]  BeMask  = BeWidth'(vldrty_be_all(NumWays));

  inval_state_e        state_q;
  logic [CntWidth-1:0] set_cnt_q;
  logic                pend_q;
  logic                sweep_q;
  logic                ack_q;

  // FSM, set counter and registered request/ack flags; grant only acts through these flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= BOOT;
      set_cnt_q <= '0;
      pend_q    <= 1'b0;
      sweep_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        BOOT: begin
          if (!init_ni) begin
            state_q <= SWEEP;
            sweep_q <= 1'b1;
            pend_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (inval_req_i) begin
            state_q   <= SWEEP;
            sweep_q   <= 1'b1;
            pend_q    <= 1'b1;
            set_cnt_q <= '0;
          end
        end
        SWEEP: begin
          // A request arriving mid-sweep is served by the sweep already running.
          if (inval_req_i) begin
            pend_q <= 1'b1;
          end
          if (gnt_i) begin
            if (set_cnt_q == LastSet) begin
              set_cnt_q <= '0;
              sweep_q   <= 1'b0;
              if (pend_q || inval_req_i) begin
                state_q <= ACK;
                ack_q   <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              set_cnt_q <= set_cnt_q + CntWidth'(1);
            end
          end
        end
        ACK: begin
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          sweep_q <= 1'b0;
        end
      endcase
    end
  end

  // Port drive: request/enables only while sweeping, data always zero.
  assign busy_o         = sweep_q;
  assign req_o          = {NumWays{sweep_q}};
  assign we_o           = sweep_q;
  assign be_vldrty_o    = sweep_q ? BeMask : '0;
  assign wdata_vldrty_o = '0;
  assign addr_o         = IndexWidth'({set_cnt_q, {ByteOffset{1'b0}}});
  assign inval_ack_o    = ack_q;

  // Request and address hold while stalled on the arbiter.
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (sweep_q && !gnt_i) |=> ($stable(req_o) && $stable(addr_o)));

  // Acknowledge is a single-cycle pulse.
  a_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    ack_q |=> !ack_q);

  // Write enable tracks any active way request.
  a_we_req: assert property (@(posedge clk_i) we_o == (|req_o));

endmodule
